// File: rtl/hazard_ctrl_param.sv
// Hazard controller for the 16-bit pipeline: operand/store-data forwarding,
// counted load-use stall, counted branch flush, global stop and perf counters.
module hazard_ctrl_param #(
    parameter int REG_WIDTH       = 4,
    parameter int LU_STALL_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES = 3,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rsD,
    input  logic [REG_WIDTH-1:0] rtD,
    input  logic                 useRsD,
    input  logic                 useRtD,
    input  logic [REG_WIDTH-1:0] rsE,
    input  logic [REG_WIDTH-1:0] rtE,
    input  logic [REG_WIDTH-1:0] WriteRegE,
    input  logic [REG_WIDTH-1:0] WriteRegM,
    input  logic [REG_WIDTH-1:0] WriteRegW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [REG_WIDTH-1:0] rsM,
    input  logic                 MemReadE,
    input  logic                 MemReadW,
    input  logic                 MemWriteM,
    input  logic                 stop,
    input  logic                 PCSrc,
    input  logic                 jump,
    output logic [1:0]           alu_src1,
    output logic [1:0]           alu_src2,
    output logic                 mem_src,
    output logic                 pcstall,
    output logic                 IF_IDstall,
    output logic                 ID_EXstall,
    output logic                 EX_MEMstall,
    output logic                 MEM_WBstall,
    output logic                 flushIF_ID,
    output logic                 flushID_EX,
    output logic                 flushEX_MEM,
    output logic                 br_busy,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int BR_W      = (BR_FLUSH_CYCLES > 1) ? $clog2(BR_FLUSH_CYCLES) : 1;
    localparam int LU_W      = (LU_STALL_CYCLES > 2) ? $clog2(LU_STALL_CYCLES - 1) : 1;
    localparam int BR_LAST_I = (BR_FLUSH_CYCLES > 1) ? BR_FLUSH_CYCLES - 1 : 0;
    localparam int LU_LAST_I = (LU_STALL_CYCLES > 2) ? LU_STALL_CYCLES - 2 : 0;
    localparam logic [BR_W-1:0] BR_LAST = BR_LAST_I[BR_W-1:0];
    localparam logic [LU_W-1:0] LU_LAST = LU_LAST_I[LU_W-1:0];

    typedef enum logic {B_IDLE, B_FLUSH}   br_state_t;
    typedef enum logic {LU_IDLE, LU_STALL} lu_state_t;

    br_state_t           br_state;
    lu_state_t           lu_state;
    logic [BR_W-1:0]     br_cnt;
    logic [LU_W-1:0]     lu_cnt;
    logic                br_event;
    logic                br_active;
    logic                lu_hazard;
    logic                lu_start;
    logic                lu_active;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_WIDTH-1:0] src);
        if (src != '0 && src == WriteRegM && RegWriteM)
            return 2'b01;
        else if (src != '0 && src == WriteRegW && RegWriteW)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        br_event  = (br_state == B_IDLE) && PCSrc && !stop;
        br_active = br_event || (br_state == B_FLUSH);
        lu_hazard = MemReadE && (WriteRegE != '0) &&
                    ((useRsD && rsD == WriteRegE) || (useRtD && rtD == WriteRegE));
        lu_start  = (lu_state == LU_IDLE) && lu_hazard && !br_active && !stop;
        lu_active = !stop && !br_active && (lu_start || lu_state == LU_STALL);
    end

    // Every output is forced low while reset is held.
    assign alu_src1    = rst ? fwd_sel(rsE) : 2'b00;
    assign alu_src2    = rst ? fwd_sel(rtE) : 2'b00;
    assign mem_src     = rst && (rsM != '0) && (rsM == WriteRegW) && MemReadW && MemWriteM;
    assign pcstall     = rst && (stop || lu_active);
    assign IF_IDstall  = rst && (stop || lu_active);
    assign ID_EXstall  = rst && stop;
    assign EX_MEMstall = rst && stop;
    assign MEM_WBstall = rst && stop;
    assign flushIF_ID  = rst && jump && !stop;
    assign flushID_EX  = rst && lu_active;
    assign flushEX_MEM = rst && br_active && !stop;
    assign br_busy     = rst && (br_state == B_FLUSH);

    // Branch flush FSM: the accepting cycle counts as the first flush cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_state    <= B_IDLE;
            br_cnt      <= '0;
            flush_count <= '0;
        end else if (!stop) begin
            case (br_state)
                B_IDLE: begin
                    if (PCSrc) begin
                        flush_count <= sat_inc(flush_count);
                        br_cnt      <= BR_W'(1);
                        if (BR_FLUSH_CYCLES > 1)
                            br_state <= B_FLUSH;
                    end
                end
                B_FLUSH: begin
                    if (br_cnt == BR_LAST) begin
                        br_state <= B_IDLE;
                        br_cnt   <= '0;
                    end else begin
                        br_cnt <= br_cnt + BR_W'(1);
                    end
                end
                default: br_state <= B_IDLE;
            endcase
        end
    end

    // Load-use FSM: the detecting cycle is the first bubble; a redirect aborts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_state    <= LU_IDLE;
            lu_cnt      <= '0;
            stall_count <= '0;
        end else if (!stop) begin
            if (lu_active)
                stall_count <= sat_inc(stall_count);
            if (br_active) begin
                lu_state <= LU_IDLE;
                lu_cnt   <= '0;
            end else if (lu_start) begin
                lu_cnt <= '0;
                if (LU_STALL_CYCLES > 1)
                    lu_state <= LU_STALL;
            end else if (lu_state == LU_STALL) begin
                if (lu_cnt == LU_LAST) begin
                    lu_state <= LU_IDLE;
                    lu_cnt   <= '0;
                end else begin
                    lu_cnt <= lu_cnt + LU_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param with 2-cycle load-use stall,
// 3-cycle branch flush and 3-bit counters (saturate at 7).
module tb_hazard_ctrl_param;
    localparam int RW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, rsM;
    logic          useRsD, useRtD, RegWriteM, RegWriteW;
    logic          MemReadE, MemReadW, MemWriteM, stop, PCSrc, jump;
    logic [1:0]    alu_src1, alu_src2;
    logic          mem_src, pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall;
    logic          flushIF_ID, flushID_EX, flushEX_MEM, br_busy;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    hazard_ctrl_param #(
        .REG_WIDTH(RW), .LU_STALL_CYCLES(2), .BR_FLUSH_CYCLES(3), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
        .WriteRegW(WriteRegW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .rsM(rsM),
        .MemReadE(MemReadE), .MemReadW(MemReadW), .MemWriteM(MemWriteM), .stop(stop),
        .PCSrc(PCSrc), .jump(jump), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .mem_src(mem_src), .pcstall(pcstall), .IF_IDstall(IF_IDstall),
        .ID_EXstall(ID_EXstall), .EX_MEMstall(EX_MEMstall), .MEM_WBstall(MEM_WBstall),
        .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX), .flushEX_MEM(flushEX_MEM),
        .br_busy(br_busy), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0; WriteRegE = '0; WriteRegM = '0;
        WriteRegW = '0; rsM = '0; useRsD = 0; useRtD = 0; RegWriteM = 0; RegWriteW = 0;
        MemReadE = 0; MemReadW = 0; MemWriteM = 0; stop = 0; PCSrc = 0; jump = 0;
    endtask

    task automatic lu_set();
        MemReadE = 1; WriteRegE = 4'd5; rsD = 4'd5; useRsD = 1;
    endtask

    task automatic chk_ctl(input string tag, input logic pc, input logic fid,
                           input logic fem, input logic busy);
        #1;
        check({tag, "/pcstall"},     32'(pcstall),     32'(pc));
        check({tag, "/IF_IDstall"},  32'(IF_IDstall),  32'(pc));
        check({tag, "/flushID_EX"},  32'(flushID_EX),  32'(fid));
        check({tag, "/ID_EXstall"},  32'(ID_EXstall),  0);
        check({tag, "/flushEX_MEM"}, 32'(flushEX_MEM), 32'(fem));
        check({tag, "/br_busy"},     32'(br_busy),     32'(busy));
    endtask

    initial begin
        clr();
        rst = 0; stop = 1; jump = 1; rsE = 4'd3; WriteRegM = 4'd3; RegWriteM = 1;
        #2;
        check("rst_pcstall",  32'(pcstall),     0);
        check("rst_mwbstall", 32'(MEM_WBstall), 0);
        check("rst_alu1",     32'(alu_src1),    0);
        check("rst_fif",      32'(flushIF_ID),  0);
        check("rst_fc",       32'(flush_count), 0);
        check("rst_sc",       32'(stall_count), 0);
        clr();
        nxt(); nxt();
        rst = 1;
        chk_ctl("idle", 0, 0, 0, 0);

        // forwarding
        rsE = 4'd3; rtE = 4'd3; WriteRegM = 4'd3; RegWriteM = 1; WriteRegW = 4'd3; RegWriteW = 1;
        #1; check("fwd_m1", 32'(alu_src1), 1); check("fwd_m2", 32'(alu_src2), 1);
        rsE = 4'd0;
        #1; check("fwd_r0", 32'(alu_src1), 0);
        rsE = 4'd3; RegWriteM = 0;
        #1; check("fwd_w1", 32'(alu_src1), 2);
        RegWriteM = 1; WriteRegM = 4'd4; rtE = 4'd4;
        #1; check("fwd_w1b", 32'(alu_src1), 2); check("fwd_m2b", 32'(alu_src2), 1);
        stop = 1;
        #1; check("fwd_stop", 32'(alu_src1), 2);
        stop = 0; RegWriteW = 0;
        #1; check("fwd_none", 32'(alu_src1), 0);
        rsM = 4'd3; WriteRegW = 4'd3; MemReadW = 1; MemWriteM = 1;
        #1; check("msrc_on", 32'(mem_src), 1);
        MemWriteM = 0;
        #1; check("msrc_nost", 32'(mem_src), 0);
        MemWriteM = 1; rsM = 4'd0; WriteRegW = 4'd0;
        #1; check("msrc_r0", 32'(mem_src), 0);
        clr();
        nxt();

        // load-use via rs
        lu_set();
        chk_ctl("lu0", 1, 1, 0, 0);
        nxt(); clr();
        chk_ctl("lu1", 1, 1, 0, 0);
        nxt();
        chk_ctl("lu2", 0, 0, 0, 0);
        check("lu_sc", 32'(stall_count), 2);
        lu_set(); useRsD = 0;
        chk_ctl("lu_nouse", 0, 0, 0, 0);
        clr(); MemReadE = 1; useRtD = 1;
        chk_ctl("lu_r0", 0, 0, 0, 0);
        clr(); WriteRegE = 4'd5; rsD = 4'd5; useRsD = 1;
        chk_ctl("lu_noload", 0, 0, 0, 0);
        clr();
        nxt();
        // load-use via rt
        MemReadE = 1; WriteRegE = 4'd7; rtD = 4'd7; useRtD = 1;
        chk_ctl("lurt0", 1, 1, 0, 0);
        nxt(); clr();
        chk_ctl("lurt1", 1, 1, 0, 0);
        nxt();
        chk_ctl("lurt2", 0, 0, 0, 0);
        check("lurt_sc", 32'(stall_count), 4);

        // branch flush with an ignored second PCSrc, then a jump
        PCSrc = 1;
        chk_ctl("br0", 0, 0, 1, 0);
        nxt();
        chk_ctl("br1", 0, 0, 1, 1);
        nxt(); PCSrc = 0;
        chk_ctl("br2", 0, 0, 1, 1);
        nxt(); jump = 1;
        chk_ctl("br3", 0, 0, 0, 0);
        check("br_fif", 32'(flushIF_ID), 1);
        check("br_fc", 32'(flush_count), 1);
        nxt(); jump = 0;
        #1; check("jmp_off", 32'(flushIF_ID), 0);

        // load-use and branch in the same cycle
        nxt();
        lu_set(); PCSrc = 1; jump = 1;
        chk_ctl("lb0", 0, 0, 1, 0);
        check("lb_fif", 32'(flushIF_ID), 1);
        nxt(); PCSrc = 0; jump = 0;
        chk_ctl("lb1", 0, 0, 1, 1);
        nxt(); clr();
        chk_ctl("lb2", 0, 0, 1, 1);
        nxt();
        chk_ctl("lb3", 0, 0, 0, 0);
        check("lb_sc", 32'(stall_count), 4);
        check("lb_fc", 32'(flush_count), 2);

        // branch aborting an ongoing stall
        lu_set();
        chk_ctl("ab0", 1, 1, 0, 0);
        nxt(); clr(); PCSrc = 1;
        chk_ctl("ab1", 0, 0, 1, 0);
        nxt(); PCSrc = 0;
        chk_ctl("ab2", 0, 0, 1, 1);
        nxt();
        chk_ctl("ab3", 0, 0, 1, 1);
        nxt();
        chk_ctl("ab4", 0, 0, 0, 0);
        check("ab_sc", 32'(stall_count), 5);
        check("ab_fc", 32'(flush_count), 3);

        // stop in the middle of a flush
        PCSrc = 1;
        chk_ctl("st0", 0, 0, 1, 0);
        nxt(); PCSrc = 0;
        chk_ctl("st1", 0, 0, 1, 1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            stop = 1; PCSrc = 1; jump = 1; lu_set();
            #1;
            check("stop_pc",   32'(pcstall),     1);
            check("stop_ifid", 32'(IF_IDstall),  1);
            check("stop_idex", 32'(ID_EXstall),  1);
            check("stop_exm",  32'(EX_MEMstall), 1);
            check("stop_mwb",  32'(MEM_WBstall), 1);
            check("stop_fem",  32'(flushEX_MEM), 0);
            check("stop_fif",  32'(flushIF_ID),  0);
            check("stop_fid",  32'(flushID_EX),  0);
            nxt();
        end
        clr();
        chk_ctl("st_r", 0, 0, 1, 1);
        nxt();
        chk_ctl("st_e", 0, 0, 0, 0);
        check("st_fc", 32'(flush_count), 4);
        check("st_sc", 32'(stall_count), 5);
        stop = 1; PCSrc = 1; lu_set();
        #1; check("stidle_fem", 32'(flushEX_MEM), 0);
        nxt(); clr();
        chk_ctl("stidle", 0, 0, 0, 0);
        check("stidle_fc", 32'(flush_count), 4);
        check("stidle_sc", 32'(stall_count), 5);

        // reset during a flush
        PCSrc = 1;
        nxt(); PCSrc = 0;
        chk_ctl("rf1", 0, 0, 1, 1);
        stop = 1; rsE = 4'd3; WriteRegM = 4'd3; RegWriteM = 1;
        rst = 0;
        #1;
        check("rf_fem",  32'(flushEX_MEM), 0);
        check("rf_busy", 32'(br_busy),     0);
        check("rf_pc",   32'(pcstall),     0);
        check("rf_mwb",  32'(MEM_WBstall), 0);
        check("rf_alu1", 32'(alu_src1),    0);
        check("rf_fc",   32'(flush_count), 0);
        check("rf_sc",   32'(stall_count), 0);
        nxt(); nxt();
        clr(); rst = 1;
        chk_ctl("rr", 0, 0, 0, 0);
        PCSrc = 1;
        chk_ctl("nf0", 0, 0, 1, 0);
        nxt(); PCSrc = 0;
        chk_ctl("nf1", 0, 0, 1, 1);
        nxt();
        chk_ctl("nf2", 0, 0, 1, 1);
        nxt();
        chk_ctl("nf3", 0, 0, 0, 0);
        check("nf_fc", 32'(flush_count), 1);
        check("nf_sc", 32'(stall_count), 0);

        // counter saturation: 9 branches and 8 bubbles into 3-bit counters
        for (int i = 0; i < 8; i++) begin
            PCSrc = 1;
            nxt(); PCSrc = 0;
            nxt();
            nxt();
        end
        #1; check("sat_fc", 32'(flush_count), 7);
        for (int i = 0; i < 4; i++) begin
            lu_set();
            nxt(); clr();
            nxt();
        end
        #1;
        check("sat_sc", 32'(stall_count), 7);
        check("sat_pc", 32'(pcstall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
